// File: rtl/prep1_ctrl.sv
// PREP1 controller: arbitrates four requesters onto a load/rotate datapath and sequences LOAD1/LOAD2/SHIFT/DONE.
// Define PREP1_CTRL_FIXED_PRI_EN for fixed priority (req[0] highest); round-robin otherwise.
module prep1_ctrl #(
    parameter int SHW = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [3:0]     req,
    input  logic [SHW-1:0] shamt,
    output logic [3:0]     gnt,
    output logic           S1,
    output logic           S0,
    output logic           S_L,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD1 = 3'd1,
        LOAD2 = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state, state_nx;
    logic [SHW-1:0] cnt, cnt_nx;
    logic [3:0]     gnt_nx;
    logic [1:0]     sel, sel_nx;
    logic [1:0]     arb_idx;
    logic           grant;

    // Search starts just after the pointer; index p itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            idx = p + k[1:0];
            if (r[idx]) rr_pick = idx;
        end
    endfunction

`ifdef PREP1_CTRL_FIXED_PRI_EN
    localparam logic [1:0] ptr = 2'd3;
`else
    logic [1:0] ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        ptr <= 2'd3;
        else if (grant) ptr <= arb_idx;
    end
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        sel_nx   = sel;
        grant    = 1'b0;
        arb_idx  = rr_pick(req, ptr);
        case (state)
            IDLE: begin
                if (|req) begin
                    grant    = 1'b1;
                    state_nx = LOAD1;
                end
            end
            LOAD1: state_nx = LOAD2;
            LOAD2: state_nx = (cnt != '0) ? SHIFT : DONE;
            SHIFT: begin
                cnt_nx = cnt - SHW'(1);
                if (cnt == SHW'(1)) state_nx = DONE;
            end
            DONE: begin
                if (|req) begin
                    grant    = 1'b1;
                    state_nx = LOAD1;
                end else begin
                    gnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Grant, select and rotate count are frozen here for the whole operation.
        if (grant) begin
            gnt_nx = 4'b0001 << arb_idx;
            sel_nx = arb_idx;
            cnt_nx = shamt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
            S_L   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            S_L   <= !((state_nx == LOAD1) || (state_nx == LOAD2));
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
        end
    end

    assign S1 = sel[1];
    assign S0 = sel[0];

endmodule

// File: tb/tb_prep1_ctrl.sv
// Bench for prep1_ctrl driving a small behavioural prep1 datapath; expected results flow through a scoreboard queue.
module tb_prep1_ctrl;

    localparam int SHW = 3;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [3:0]     req = '0;
    logic [SHW-1:0] shamt = '0;
    logic [3:0]     gnt;
    logic           S1, S0, S_L, busy, done;

    logic [7:0] d [4];
    logic [7:0] q_reg = '0;
    logic [7:0] Q = '0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] q;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    prep1_ctrl #(.SHW(SHW)) dut (
        .CLK(CLK), .RST(RST), .req(req), .shamt(shamt),
        .gnt(gnt), .S1(S1), .S0(S0), .S_L(S_L), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Datapath: load stage then rotate-left-by-one per cycle in rotate mode.
    always @(posedge CLK) begin
        if (!S_L) begin
            q_reg <= d[{S1, S0}];
            Q     <= q_reg;
        end else begin
            Q <= {Q[6:0], Q[7]};
        end
    end

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] t;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int idx, input int s);
        exp_t e;
        e.gnt = 4'b0001 << idx;
        e.sel = 2'(idx);
        e.q   = rotl8(d[idx], s);
        e.lat = 3 + s;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_sel"}, 32'({S1, S0}), 32'h0);
        chk({tag, "_sl"}, 32'(S_L), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // n counts negedges since stimulus (or the previous done); n==1 is LOAD1.
    task automatic wait_done(input string tag, input int drop_at, input logic [3:0] req_after,
                             input int sh_at, input logic [SHW-1:0] sh_after);
        int   n;
        bit   seen;
        exp_t e;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge CLK);
            n++;
            if ((n == 1 || n == 2) && sb.size() > 0) begin
                chk({tag, "_load_sl"}, 32'(S_L), 32'h0);
                chk({tag, "_load_busy"}, 32'(busy), 32'h1);
                chk({tag, "_load_gnt"}, 32'(gnt), 32'(sb[0].gnt));
            end
            if (done) begin
                seen = 1'b1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
                    chk({tag, "_sel"}, 32'({S1, S0}), 32'(e.sel));
                    chk({tag, "_q"}, 32'(Q), 32'(e.q));
                    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
                end else begin
                    chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'h1);
                end
            end
            if (n == drop_at) req = req_after;
            if (n == sh_at) shamt = sh_after;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'h1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge CLK);
        chk({tag, "_idle_done"}, 32'(done), 32'h0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
        chk({tag, "_idle_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_idle_sl"}, 32'(S_L), 32'h1);
    endtask

    initial begin
        int order[5];
        for (int i = 0; i < 4; i++) d[i] = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check_reset_vals("rst");
        RST = 1'b0;
        @(negedge CLK);
        check_reset_vals("post_rst");

        // Requester 2, rotate by 3
        d[2] = 8'h81; req = 4'b0100; shamt = 3'd3;
        push(2, 3);
        wait_done("r031", 1, 4'b0000, 0, '0);
        check_idle("r031");

        // Requester 0, no rotate: SHIFT skipped
        d[0] = 8'h5A; req = 4'b0001; shamt = 3'd0;
        push(0, 0);
        wait_done("r032", 1, 4'b0000, 0, '0);
        check_idle("r032");

        // Requester 3, req dropped and shamt changed mid-operation
        d[3] = 8'h3C; req = 4'b1000; shamt = 3'd2;
        push(3, 2);
        wait_done("r035", 1, 4'b0000, 2, 3'd0);
        check_idle("r035a");
        check_idle("r035b");

        // All requesters held: back-to-back arbitration
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h44; d[3] = 8'h88;
        req = 4'b1111; shamt = 3'd1;
`ifdef PREP1_CTRL_FIXED_PRI_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) push(order[i], 1);
        for (int i = 0; i < 4; i++) wait_done($sformatf("r033_%0d", i), 0, 4'b0000, 0, '0);
        wait_done("r033_4", 1, 4'b0000, 0, '0);
        check_idle("r033");

        // Reset during SHIFT aborts with no done
        d[1] = 8'hA5; req = 4'b0010; shamt = 3'd7;
        repeat (4) @(negedge CLK);
        chk("r034_shift_busy", 32'(busy), 32'h1);
        chk("r034_shift_sl", 32'(S_L), 32'h1);
        chk("r034_shift_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        #2 RST = 1'b1;
        #1 check_reset_vals("r034_async");
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("r034_no_done", 32'(done), 32'h0);
            chk("r034_no_busy", 32'(busy), 32'h0);
        end
        d[0] = 8'h77; req = 4'b0011; shamt = 3'd0;
        push(0, 0);
        wait_done("r034_next", 1, 4'b0000, 0, '0);
        check_idle("r034");

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prep1_ctrl.md
PREP1_CTRL -- requirements
Module: prep1_ctrl

Interface
REQ-001 Parameter SHW, default 3: width of the shift-amount input; maximum rotate is 2^SHW-1.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request from requester i; requester i owns datapath source d_i.
REQ-005 shamt  input  SHW  rotate-left amount, shared by all requesters, sampled at grant.
REQ-006 gnt  output  4  one-hot grant, held from the LOAD1 state through the DONE state.
REQ-007 S1, S0  output  1 each  datapath mux select; {S1,S0} = index of the granted requester.
REQ-008 S_L  output  1  datapath mode; 0 = load, 1 = rotate.
REQ-009 busy  output  1  high in the LOAD1, LOAD2, SHIFT and DONE states.
REQ-010 done  output  1  single-cycle pulse; the datapath Q holds rotl(d_gnt, shamt) during this cycle.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 The FSM SHALL have the states IDLE, LOAD1, LOAD2, SHIFT and DONE.
REQ-013 IDLE: S_L=1, gnt=0; if req is nonzero, arbitrate and go to LOAD1 on the next edge; otherwise stay in IDLE.
REQ-014 At the arbitration edge, capture gnt, {S1,S0} and shamt into a down-counter.
REQ-015 LOAD1: S_L=0 (datapath q_reg captures d_gnt); always go to LOAD2.
REQ-016 LOAD2: S_L=0 (datapath Q captures q_reg); go to SHIFT if the counter is nonzero, otherwise go to DONE.
REQ-017 SHIFT: S_L=1; decrement the counter each cycle; go to DONE in the cycle the counter reaches 1; stay in SHIFT for exactly shamt cycles.
REQ-018 DONE: done=1, S_L=1.
REQ-019 DONE exit: if req is nonzero, re-arbitrate and go directly to LOAD1 (back-to-back, no IDLE cycle); otherwise go to IDLE with gnt=0.
REQ-020 Latency: done is asserted exactly 2+shamt cycles after the first LOAD1 cycle.
REQ-021 Round-robin: the search starts at the index after the last granted index, wrapping 3->0; after reset the pointer gives req[0] highest priority.
REQ-022 The pointer SHALL update only when a grant is issued.
REQ-023 Deasserting req or changing shamt mid-operation SHALL NOT affect the operation in progress.
REQ-024 Requester i SHALL hold d_i stable during LOAD1; the controller does not check this.
REQ-025 A single pending requester SHALL be re-granted back-to-back indefinitely.

Reset
REQ-026 While RST is high: state=IDLE, gnt=0, S1=S0=0, S_L=1, busy=0, done=0, counter=0, RR pointer=3 (so req[0] wins next).
REQ-027 RST asserted mid-operation SHALL abort immediately with no done pulse; the first grant after release follows REQ-026 priority.

Configuration
REQ-028 Macro PREP1_CTRL_FIXED_PRI_EN.
REQ-029 When defined: fixed priority, req[0] highest and req[3] lowest; the RR pointer is not implemented.
REQ-030 When undefined: round-robin per REQ-021 and REQ-022; all other behaviour is identical in both builds.

Verification (bench instantiates prep1_ctrl driving a prep1 datapath)
REQ-031 req=4'b0100, shamt=3, d2=8'h81 -> gnt=4'b0100, {S1,S0}=2'b10; done 5 cycles after the first LOAD1 cycle; Q=8'h0C during done.
REQ-032 req=4'b0001, shamt=0, d0=8'h5A -> the SHIFT state is skipped; done 2 cycles after the first LOAD1 cycle; Q=8'h5A.
REQ-033 req=4'b1111 held, shamt=1 (round-robin build) -> grant order 0,1,2,3,0; no IDLE cycle between operations.
REQ-033 (fixed-priority build) same stimulus -> req[0] is granted continuously.
REQ-034 req=4'b0010, shamt=7 -> RST pulsed during SHIFT -> all outputs at reset values asynchronously, no done pulse; the next req=4'b0011 grants 4'b0001.
REQ-035 req=4'b1000 dropped after 1 cycle, shamt changed to 0 during LOAD2 -> the operation completes with the original shamt; a single done pulse; then IDLE.
